// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared debug types and defaults for the MIPS32 end-of-program dump engine
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        DS_IDLE  = 3'd0,
        DS_DRAIN = 3'd1,
        DS_RD    = 3'd2,
        DS_LOAD  = 3'd3,
        DS_SEND  = 3'd4,
        DS_DONE  = 3'd5
    } dump_state_e;

    localparam logic [31:0] DEF_END_PC     = 32'h80;
    localparam int          DEF_BASE_WORD  = 32;
    localparam int          DEF_WORD_COUNT = 96;
    localparam int          EOL_LEN        = 16;

endpackage

// File: rtl/dm_dump_engine_if.sv
// dm_dump_engine_if: data-memory read port plus valid/ready word stream of the dump engine
interface dm_dump_engine_if #(
    parameter int ADDR_W = 8
) ();

    logic              dm_rd_en;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_last;
    logic              out_eol;

    modport master (
        output dm_rd_en, dm_addr, out_valid, out_data, out_last, out_eol,
        input  dm_rdata, out_ready
    );

    modport slave (
        input  dm_rd_en, dm_addr, out_valid, out_data, out_last, out_eol,
        output dm_rdata, out_ready
    );

endinterface

// File: rtl/dm_dump_engine.sv
// dm_dump_engine: stalls the core at END_PC, drains, then streams a window of data memory
// Optional DM_DUMP_EOL_EN: flags every 16th streamed word with out_eol.
module dm_dump_engine
    import mips_dbg_pkg::*;
#(
    parameter logic [31:0] END_PC       = DEF_END_PC,
    parameter int          BASE_WORD    = DEF_BASE_WORD,
    parameter int          WORD_COUNT   = DEF_WORD_COUNT,
    parameter int          ADDR_W       = 8,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_i,
    output logic             stall_o,
    output logic             done_o,
    dm_dump_engine_if.master bus
);

    localparam int IDX_W = $clog2(WORD_COUNT + 1);
    localparam int CNT_W = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [2:0] S_IDLE  = DS_IDLE;
    localparam logic [2:0] S_DRAIN = DS_DRAIN;
    localparam logic [2:0] S_RD    = DS_RD;
    localparam logic [2:0] S_LOAD  = DS_LOAD;
    localparam logic [2:0] S_SEND  = DS_SEND;
    localparam logic [2:0] S_DONE  = DS_DONE;

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             last_w;

    assign last_w      = idx == IDX_W'(WORD_COUNT - 1);
    assign stall_o     = state != S_IDLE;
    assign done_o      = state == S_DONE;
    assign bus.dm_rd_en = state == S_RD;
    assign bus.dm_addr  = bus.dm_rd_en ? ADDR_W'(32'(BASE_WORD) + 32'(idx)) : '0;

    // Dump sequencer: trigger, drain, then one RD/LOAD/SEND round per word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (pc_i == END_PC) begin
                    state <= DRAIN_CYCLES == 0 ? S_RD : S_DRAIN;
                    idx   <= '0;
                    cnt   <= '0;
                end
                S_DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (32'(cnt) + 32'd1 == 32'(DRAIN_CYCLES)) state <= S_RD;
                end
                S_RD: state <= S_LOAD;
                S_LOAD: begin
                    bus.out_data  <= bus.dm_rdata;
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= last_w;
                    state         <= S_SEND;
                end
                S_SEND: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    if (bus.out_last) state <= S_DONE;
                    else begin
                        idx   <= idx + 1'b1;
                        state <= S_RD;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DM_DUMP_EOL_EN
    // End-of-line flag travels with the word it marks and clears on its handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.out_eol <= 1'b0;
        else if (state == S_LOAD) bus.out_eol <= 32'(idx) % 32'(EOL_LEN) == 32'(EOL_LEN - 1);
        else if (state == S_SEND && bus.out_ready) bus.out_eol <= 1'b0;
    end
`else
    assign bus.out_eol = 1'b0;
`endif

endmodule
